mac_pktbuf: RTL and testbench

//  Single-port packet RAM with three Wishbone slave ports. Receives minimac RX DMA writes (wbrx), serves

---
 rtl/mac_pktbuf_pkg.sv | 22 ++
 rtl/mac_pktbuf_ram.sv | 25 ++
 rtl/mac_pktbuf.sv | 191 +++++++++++++++++++
 tb/tb_mac_pktbuf.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pktbuf_pkg.sv
// Shared constants and types for the packet buffer: Wishbone cycle-type codes,
// arbiter grant encoding and statistics width.
package mac_pktbuf_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam int STAT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    G_RX  = 2'd1,
    G_TX  = 2'd2,
    G_CPU = 2'd3
  } grant_e;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mac_pktbuf_ram.sv
// 2**AW x 32 single-port synchronous RAM with byte write enables and a
// registered read port (read-before-write), shaped for block-RAM inference.
module mac_pktbuf_ram #(
  parameter int AW = 10
) (
  input  logic          clk_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdat_i,
  output logic [31:0]   rdat_o
);

  logic [31:0] mem_q [2**AW];
  logic [31:0] rdat_q;

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdat_i[8*b +: 8];
    end
    rdat_q <= mem_q[addr_i];
  end

  assign rdat_o = rdat_q;

endmodule

// File: rtl/mac_pktbuf.sv
// Packet buffer RAM shared by the minimac RX DMA (write), TX DMA (read) and CPU
// (byte-granular) Wishbone ports. Define MAC_PKTBUF_STATS_EN for word counters.
module mac_pktbuf
  import mac_pktbuf_pkg::*;
#(
  parameter int          AW   = 10,
  parameter logic [31:0] BASE = 32'h0000_0000
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [31:0]       wbrx_adr_i,
  input  logic [2:0]        wbrx_cti_i,
  input  logic              wbrx_cyc_i,
  input  logic              wbrx_stb_i,
  input  logic [31:0]       wbrx_dat_i,
  output logic              wbrx_ack_o,
  input  logic [31:0]       wbtx_adr_i,
  input  logic [2:0]        wbtx_cti_i,
  input  logic              wbtx_cyc_i,
  input  logic              wbtx_stb_i,
  output logic [31:0]       wbtx_dat_o,
  output logic              wbtx_ack_o,
  input  logic [31:0]       wbc_adr_i,
  input  logic [31:0]       wbc_dat_i,
  input  logic [3:0]        wbc_sel_i,
  input  logic              wbc_we_i,
  input  logic              wbc_cyc_i,
  input  logic              wbc_stb_i,
  output logic [31:0]       wbc_dat_o,
  output logic              wbc_ack_o,
  output logic              oow_err,
  output logic [STAT_W-1:0] stat_rx_words,
  output logic [STAT_W-1:0] stat_tx_words
);

  grant_e        grant_q, grant_d;
  logic          ack_q, ack_d;
  logic          cont_q, cont_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          win_q;
  logic [31:0]   tx_hold_q, cpu_hold_q;
  logic          oow_q;

  logic          s_cyc, s_stb;
  logic [31:0]   s_adr;
  logic [2:0]    s_cti;
  logic [AW-1:0] cur_word, ram_addr;
  logic          cur_win, beat;
  logic [3:0]    ram_we;
  logic [31:0]   ram_wdat, ram_rdat, rd_data;
  logic          rx_ack, tx_ack, cpu_ack;
  logic          unused_adr_bits;

  function automatic logic in_win(input logic [31:0] a);
    return a[31:AW+2] == BASE[31:AW+2];
  endfunction

  // Signals of whichever port currently holds the grant
  always_comb begin
    s_cyc = 1'b0;
    s_stb = 1'b0;
    s_adr = '0;
    s_cti = CTI_CLASSIC;
    case (grant_q)
      G_RX: begin
        s_cyc = wbrx_cyc_i;
        s_stb = wbrx_stb_i;
        s_adr = wbrx_adr_i;
        s_cti = wbrx_cti_i;
      end
      G_TX: begin
        s_cyc = wbtx_cyc_i;
        s_stb = wbtx_stb_i;
        s_adr = wbtx_adr_i;
        s_cti = wbtx_cti_i;
      end
      G_CPU: begin
        s_cyc = wbc_cyc_i;
        s_stb = wbc_stb_i;
        s_adr = wbc_adr_i;
      end
      default: ;
    endcase
  end

  assign unused_adr_bits = ^s_adr[1:0];

  always_comb begin
    grant_d = grant_q;
    ack_d   = 1'b0;
    cont_d  = 1'b0;
    if (grant_q == IDLE) begin
      if (wbrx_cyc_i && wbrx_stb_i)      grant_d = G_RX;
      else if (wbtx_cyc_i && wbtx_stb_i) grant_d = G_TX;
      else if (wbc_cyc_i && wbc_stb_i)   grant_d = G_CPU;
    end else if (!s_cyc) begin
      grant_d = IDLE;
    end else if (ack_q) begin
      if (s_cti == CTI_EOB) begin
        grant_d = IDLE;
      end else if (s_cti == CTI_INCR && s_stb) begin
        ack_d  = 1'b1;
        cont_d = 1'b1;
      end
    end else if (s_stb) begin
      ack_d = 1'b1;
    end
  end

  // Continued burst beats follow an internal pointer so the word index wraps
  // inside the window and the window check sticks to the first beat.
  assign cur_word = cont_q ? ptr_q : s_adr[AW+1:2];
  assign cur_win  = cont_q ? win_q : in_win(s_adr);
  assign ptr_d    = cur_word + 1'b1;
  assign beat     = ack_q && s_cyc && s_stb;

  // TX prefetches the next word while the current one is being acked
  assign ram_addr = (grant_q == G_TX && ack_q) ? ptr_d : cur_word;
  assign ram_wdat = (grant_q == G_RX) ? wbrx_dat_i : wbc_dat_i;

  always_comb begin
    ram_we = '0;
    if (beat && cur_win && !sys_rst) begin
      if (grant_q == G_RX)                  ram_we = 4'hF;
      else if (grant_q == G_CPU && wbc_we_i) ram_we = wbc_sel_i;
    end
  end

  mac_pktbuf_ram #(.AW(AW)) u_ram (
    .clk_i  (sys_clk),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdat_i (ram_wdat),
    .rdat_o (ram_rdat)
  );

  assign rd_data = cur_win ? ram_rdat : 32'h0;
  assign rx_ack  = ack_q && (grant_q == G_RX);
  assign tx_ack  = ack_q && (grant_q == G_TX);
  assign cpu_ack = ack_q && (grant_q == G_CPU);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      grant_q    <= IDLE;
      ack_q      <= 1'b0;
      cont_q     <= 1'b0;
      ptr_q      <= '0;
      win_q      <= 1'b0;
      tx_hold_q  <= '0;
      cpu_hold_q <= '0;
      oow_q      <= 1'b0;
    end else begin
      grant_q <= grant_d;
      ack_q   <= ack_d;
      cont_q  <= cont_d;
      ptr_q   <= ptr_d;
      win_q   <= cur_win;
      if (tx_ack)             tx_hold_q  <= rd_data;
      if (cpu_ack)            cpu_hold_q <= rd_data;
      if (beat && !cur_win)   oow_q      <= 1'b1;
    end
  end

  assign wbrx_ack_o = rx_ack;
  assign wbtx_ack_o = tx_ack;
  assign wbc_ack_o  = cpu_ack;
  assign wbtx_dat_o = tx_ack  ? rd_data : tx_hold_q;
  assign wbc_dat_o  = cpu_ack ? rd_data : cpu_hold_q;
  assign oow_err    = oow_q;

`ifdef MAC_PKTBUF_STATS_EN
  logic [STAT_W-1:0] rx_cnt_q, tx_cnt_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_cnt_q <= '0;
      tx_cnt_q <= '0;
    end else if (beat && cur_win) begin
      if (grant_q == G_RX) rx_cnt_q <= sat_inc(rx_cnt_q);
      if (grant_q == G_TX) tx_cnt_q <= sat_inc(tx_cnt_q);
    end
  end

  assign stat_rx_words = rx_cnt_q;
  assign stat_tx_words = tx_cnt_q;
`else
  assign stat_rx_words = '0;
  assign stat_tx_words = '0;
`endif

endmodule

// File: tb/tb_mac_pktbuf.sv
// Directed bench for mac_pktbuf: CPU byte writes, classic timing, RX/TX bursts,
// arbitration, wrap, out-of-window and mid-burst reset.
module tb_mac_pktbuf;
  import mac_pktbuf_pkg::*;

  localparam int AW = 10;
`ifdef MAC_PKTBUF_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [31:0] wbrx_adr_i = '0, wbrx_dat_i = '0;
  logic [2:0]  wbrx_cti_i = '0;
  logic        wbrx_cyc_i = 1'b0, wbrx_stb_i = 1'b0, wbrx_ack_o;
  logic [31:0] wbtx_adr_i = '0, wbtx_dat_o;
  logic [2:0]  wbtx_cti_i = '0;
  logic        wbtx_cyc_i = 1'b0, wbtx_stb_i = 1'b0, wbtx_ack_o;
  logic [31:0] wbc_adr_i = '0, wbc_dat_i = '0, wbc_dat_o;
  logic [3:0]  wbc_sel_i = '0;
  logic        wbc_we_i = 1'b0, wbc_cyc_i = 1'b0, wbc_stb_i = 1'b0, wbc_ack_o;
  logic        oow_err;
  logic [15:0] stat_rx_words, stat_tx_words;

  int checks = 0;
  int passes = 0;
  logic [31:0] tx_rd [8];

  always #5 sys_clk = ~sys_clk;

  mac_pktbuf #(.AW(AW), .BASE(32'h0000_0000)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .wbrx_adr_i(wbrx_adr_i), .wbrx_cti_i(wbrx_cti_i), .wbrx_cyc_i(wbrx_cyc_i),
    .wbrx_stb_i(wbrx_stb_i), .wbrx_dat_i(wbrx_dat_i), .wbrx_ack_o(wbrx_ack_o),
    .wbtx_adr_i(wbtx_adr_i), .wbtx_cti_i(wbtx_cti_i), .wbtx_cyc_i(wbtx_cyc_i),
    .wbtx_stb_i(wbtx_stb_i), .wbtx_dat_o(wbtx_dat_o), .wbtx_ack_o(wbtx_ack_o),
    .wbc_adr_i(wbc_adr_i), .wbc_dat_i(wbc_dat_i), .wbc_sel_i(wbc_sel_i),
    .wbc_we_i(wbc_we_i), .wbc_cyc_i(wbc_cyc_i), .wbc_stb_i(wbc_stb_i),
    .wbc_dat_o(wbc_dat_o), .wbc_ack_o(wbc_ack_o), .oow_err(oow_err),
    .stat_rx_words(stat_rx_words), .stat_tx_words(stat_tx_words)
  );

  task automatic tick();
    @(posedge sys_clk); #1;
  endtask

  task automatic cpu_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, output logic [31:0] rdat, output logic ok);
    int n = 0;
    ok = 1'b0; rdat = '0;
    wbc_cyc_i = 1'b1; wbc_stb_i = 1'b1; wbc_we_i = we;
    wbc_adr_i = adr; wbc_dat_i = dat; wbc_sel_i = sel;
    while (!ok && n < 20) begin
      @(negedge sys_clk);
      if (wbc_ack_o) begin ok = 1'b1; rdat = wbc_dat_o; end
      tick(); n++;
    end
    wbc_cyc_i = 1'b0; wbc_stb_i = 1'b0; wbc_we_i = 1'b0;
    if (!ok) begin checks++; $display("FAIL cpu_timeout adr=%h got no ack want ack", adr); end
    tick();
  endtask

  // rst_beat>0: pulse reset during the ack cycle of that beat and stop there
  task automatic rx_burst(input int word0, input int n, input logic [31:0] d0, input int rst_beat,
                          output int lat, output int gaps, output logic ack_after);
    int beat = 0, c = 0;
    bit seen = 0, stop = 0;
    lat = -1; gaps = 0; ack_after = 1'bx;
    wbrx_cyc_i = 1'b1; wbrx_stb_i = 1'b1;
    wbrx_adr_i = 32'(word0 * 4); wbrx_dat_i = d0;
    wbrx_cti_i = (n == 1) ? CTI_EOB : CTI_INCR;
    while (beat < n && c < 100 && !stop) begin
      @(negedge sys_clk);
      if (wbrx_ack_o) begin
        if (!seen) lat = c;
        seen = 1; beat++;
        if (beat == rst_beat) sys_rst = 1'b1;
      end else if (seen) gaps++;
      tick(); c++;
      if (sys_rst) begin ack_after = wbrx_ack_o; sys_rst = 1'b0; stop = 1; end
      wbrx_adr_i = 32'((word0 + beat) * 4);
      wbrx_dat_i = d0 + 32'(beat);
      wbrx_cti_i = (beat == n - 1) ? CTI_EOB : CTI_INCR;
    end
    wbrx_cyc_i = 1'b0; wbrx_stb_i = 1'b0; wbrx_cti_i = CTI_CLASSIC;
    if (beat < n && !stop) begin checks++; $display("FAIL rx_timeout beats=%0d want %0d", beat, n); end
    tick();
  endtask

  task automatic tx_burst(input int word0, input int n, output int lat, output int gaps);
    int beat = 0, c = 0;
    bit seen = 0;
    lat = -1; gaps = 0;
    wbtx_cyc_i = 1'b1; wbtx_stb_i = 1'b1;
    wbtx_adr_i = 32'(word0 * 4);
    wbtx_cti_i = (n == 1) ? CTI_EOB : CTI_INCR;
    while (beat < n && c < 100) begin
      @(negedge sys_clk);
      if (wbtx_ack_o) begin
        if (!seen) lat = c;
        seen = 1; tx_rd[beat] = wbtx_dat_o; beat++;
      end else if (seen) gaps++;
      tick(); c++;
      wbtx_adr_i = 32'((word0 + beat) * 4);
      wbtx_cti_i = (beat == n - 1) ? CTI_EOB : CTI_INCR;
    end
    wbtx_cyc_i = 1'b0; wbtx_stb_i = 1'b0; wbtx_cti_i = CTI_CLASSIC;
    if (beat < n) begin checks++; $display("FAIL tx_timeout beats=%0d want %0d", beat, n); end
    tick();
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (3) tick();
    sys_rst = 1'b0;
    @(negedge sys_clk);
    checks++; if ({wbrx_ack_o, wbtx_ack_o, wbc_ack_o} !== 3'b000)
      $display("FAIL reset_acks got %b want 000", {wbrx_ack_o, wbtx_ack_o, wbc_ack_o}); else passes++;
    checks++; if ({wbtx_dat_o, wbc_dat_o} !== 64'h0)
      $display("FAIL reset_dat got %h/%h want 0/0", wbtx_dat_o, wbc_dat_o); else passes++;
    checks++; if (oow_err !== 1'b0) $display("FAIL reset_oow got %b want 0", oow_err); else passes++;
    checks++; if ({stat_rx_words, stat_tx_words} !== 32'h0)
      $display("FAIL reset_stats got %h/%h want 0/0", stat_rx_words, stat_tx_words); else passes++;
    tick();
  endtask

  task automatic test_cpu_bytes();
    logic [31:0] r; logic ok;
    cpu_access(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, r, ok);
    cpu_access(1'b1, 32'h10, 32'h0000_0011, 4'b0001, r, ok);
    cpu_access(1'b0, 32'h10, 32'h0, 4'b0000, r, ok);
    checks++; if (r !== 32'hDEADBE11) $display("FAIL cpu_sel0001 got %h want DEADBE11", r); else passes++;
    cpu_access(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, r, ok);
    checks++; if (ok !== 1'b1) $display("FAIL cpu_sel0000_ack got %b want 1", ok); else passes++;
    cpu_access(1'b0, 32'h10, 32'h0, 4'b0000, r, ok);
    checks++; if (r !== 32'hDEADBE11) $display("FAIL cpu_sel0000_nowrite got %h want DEADBE11", r); else passes++;
    cpu_access(1'b1, 32'h14, 32'h0077_0000, 4'b0100, r, ok);
    cpu_access(1'b1, 32'h14, 32'h1234_5678, 4'b1011, r, ok);
    cpu_access(1'b0, 32'h14, 32'h0, 4'b0000, r, ok);
    checks++; if (r !== 32'h1277_5678) $display("FAIL cpu_sel_mixed got %h want 12775678", r); else passes++;
  endtask

  task automatic test_classic_ack();
    logic [5:0] pat = '0; logic [31:0] d = '0;
    wbc_cyc_i = 1'b1; wbc_stb_i = 1'b1; wbc_we_i = 1'b0; wbc_adr_i = 32'h10;
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk);
      pat[i] = wbc_ack_o;
      if (i == 2) d = wbc_dat_o;
      tick();
      if (i == 4) begin wbc_cyc_i = 1'b0; wbc_stb_i = 1'b0; end
    end
    tick();
    checks++; if (pat !== 6'b010100) $display("FAIL classic_ack_pattern got %b want 010100", pat); else passes++;
    checks++; if (d !== 32'hDEADBE11) $display("FAIL classic_read got %h want DEADBE11", d); else passes++;
  endtask

  task automatic test_burst();
    int lat, gaps; logic aa;
    rx_burst(0, 8, 32'h0, 0, lat, gaps, aa);
    checks++; if (lat !== 2) $display("FAIL rx_first_ack_cycle got %0d want 2", lat); else passes++;
    checks++; if (gaps !== 0) $display("FAIL rx_ack_gaps got %0d want 0", gaps); else passes++;
    tx_burst(0, 8, lat, gaps);
    checks++; if (lat !== 2) $display("FAIL tx_first_ack_cycle got %0d want 2", lat); else passes++;
    checks++; if (gaps !== 0) $display("FAIL tx_ack_gaps got %0d want 0", gaps); else passes++;
    for (int i = 0; i < 8; i++) begin
      checks++; if (tx_rd[i] !== 32'(i)) $display("FAIL tx_data[%0d] got %h want %h", i, tx_rd[i], 32'(i));
      else passes++;
    end
    checks++; if (stat_rx_words !== (STATS ? 16'd8 : 16'd0))
      $display("FAIL stat_rx got %0d want %0d", stat_rx_words, STATS ? 8 : 0); else passes++;
    checks++; if (stat_tx_words !== (STATS ? 16'd8 : 16'd0))
      $display("FAIL stat_tx got %0d want %0d", stat_tx_words, STATS ? 8 : 0); else passes++;
  endtask

  task automatic test_priority();
    int rl, rg, tl, tg, bad = 0, k = 0; logic aa; bit rd = 0, td = 0;
    logic [31:0] r; logic ok;
    fork
      begin rx_burst(16, 8, 32'h100, 0, rl, rg, aa); rd = 1; end
      begin tx_burst(0, 8, tl, tg); td = 1; end
      begin
        while (!(rd && td) && k < 300) begin
          @(negedge sys_clk);
          if (wbtx_ack_o && wbrx_cyc_i) bad++;
          k++;
        end
      end
    join
    checks++; if (bad !== 0) $display("FAIL tx_ack_during_rx got %0d want 0", bad); else passes++;
    checks++; if (rl !== 2 || rg !== 0) $display("FAIL rx_wins got lat=%0d gaps=%0d want 2/0", rl, rg); else passes++;
    checks++; if (tx_rd[0] !== 32'h0 || tx_rd[7] !== 32'h7)
      $display("FAIL tx_after_rx got %h..%h want 0..7", tx_rd[0], tx_rd[7]); else passes++;
    cpu_access(1'b0, 32'h5C, 32'h0, 4'b0000, r, ok);
    checks++; if (r !== 32'h107) $display("FAIL rx_burst_word23 got %h want 00000107", r); else passes++;
    checks++; if (stat_rx_words !== (STATS ? 16'd16 : 16'd0))
      $display("FAIL stat_rx_16 got %0d want %0d", stat_rx_words, STATS ? 16 : 0); else passes++;
  endtask

  task automatic test_wrap();
    int lat, gaps; logic aa; logic [31:0] r; logic ok;
    logic [31:0] adrs [4] = '{32'hFF8, 32'hFFC, 32'h0, 32'h4};
    rx_burst(1022, 4, 32'hA0, 0, lat, gaps, aa);
    for (int i = 0; i < 4; i++) begin
      cpu_access(1'b0, adrs[i], 32'h0, 4'b0000, r, ok);
      checks++; if (r !== 32'hA0 + 32'(i)) $display("FAIL wrap_word adr=%h got %h want %h", adrs[i], r, 32'hA0 + 32'(i));
      else passes++;
    end
    checks++; if (oow_err !== 1'b0) $display("FAIL wrap_no_oow got %b want 0", oow_err); else passes++;
  endtask

  task automatic test_oow();
    logic [31:0] r; logic ok;
    cpu_access(1'b1, 32'h1000, 32'hCAFEF00D, 4'b1111, r, ok);
    checks++; if (ok !== 1'b1) $display("FAIL oow_write_ack got %b want 1", ok); else passes++;
    checks++; if (oow_err !== 1'b1) $display("FAIL oow_err_set got %b want 1", oow_err); else passes++;
    cpu_access(1'b0, 32'h1000, 32'h0, 4'b0000, r, ok);
    checks++; if (r !== 32'h0) $display("FAIL oow_read got %h want 0", r); else passes++;
    cpu_access(1'b0, 32'h0, 32'h0, 4'b0000, r, ok);
    checks++; if (r !== 32'hA2) $display("FAIL oow_ram_unchanged got %h want 000000A2", r); else passes++;
  endtask

  task automatic test_reset_midburst();
    int lat, gaps; logic aa; logic [31:0] r; logic ok;
    cpu_access(1'b1, 32'h108, 32'h5555AAAA, 4'b1111, r, ok);
    rx_burst(64, 6, 32'h600, 3, lat, gaps, aa);
    checks++; if (aa !== 1'b0) $display("FAIL rst_ack_drop got %b want 0", aa); else passes++;
    checks++; if (oow_err !== 1'b0) $display("FAIL rst_oow_clear got %b want 0", oow_err); else passes++;
    checks++; if ({stat_rx_words, stat_tx_words} !== 32'h0)
      $display("FAIL rst_stats got %h/%h want 0/0", stat_rx_words, stat_tx_words); else passes++;
    checks++; if (wbtx_dat_o !== 32'h0) $display("FAIL rst_tx_dat got %h want 0", wbtx_dat_o); else passes++;
    cpu_access(1'b0, 32'h104, 32'h0, 4'b0000, r, ok);
    checks++; if (r !== 32'h601) $display("FAIL rst_beat2_written got %h want 00000601", r); else passes++;
    cpu_access(1'b0, 32'h108, 32'h0, 4'b0000, r, ok);
    checks++; if (r !== 32'h5555AAAA) $display("FAIL rst_beat3_blocked got %h want 5555AAAA", r); else passes++;
  endtask

  initial begin
    #1;
    test_reset();
    test_cpu_bytes();
    test_classic_ack();
    test_burst();
    test_priority();
    test_wrap();
    test_oow();
    test_reset_midburst();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1);
  end

endmodule
